// File: rtl/prbs_link_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prbs_link_pkg
// Description : Shared types and default constants for the PRBS7 link-test
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package prbs_link_pkg;

    localparam int ERR_TOTAL_W         = 32;

    localparam int DEF_WINDOW_LOG2     = 24;
    localparam int DEF_SETTLE          = 64;
    localparam int DEF_ALIGN_TIMEOUT   = 65536;
    localparam int DEF_RST_CYCLES      = 4;
    localparam int DEF_MAX_RETRY       = 3;
    localparam int DEF_ERR_LIMIT       = 0;
    localparam int DEF_ERRW            = 7;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ALIGN_RST  = 3'd1,
        ST_WAIT_ALIGN = 3'd2,
        ST_SETTLE_ST  = 3'd3,
        ST_MEASURE    = 3'd4,
        ST_DONE       = 3'd5,
        ST_FAIL       = 3'd6
    } state_e;

endpackage : prbs_link_pkg
`default_nettype wire

// File: rtl/prbs_link_test_ctrl_accum.sv
`default_nettype none
// ============================================================================
// Module      : sat_accum
// Description : Saturating accumulator of per-word error-bit counts, with a
//               synchronous clear that takes priority over accumulation.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_accum
    import prbs_link_pkg::*;
#(
    parameter int IN_W  = DEF_ERRW,
    parameter int ACC_W = ERR_TOTAL_W
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic [IN_W-1:0]  data_i,
    output logic [ACC_W-1:0] acc_o,
    output logic [ACC_W-1:0] next_o
);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W:0]   w_sum;

    always_comb begin
        w_sum = {1'b0, acc_q} + {{(ACC_W + 1 - IN_W){1'b0}}, data_i};
        acc_d = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (en_i) begin
            // carry out of the top bit means the true sum no longer fits
            acc_d = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o  = acc_q;
    assign next_o = acc_d;

endmodule : sat_accum
`default_nettype wire

// File: rtl/prbs_link_test_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : prbs_link_test_ctrl
// Description : PRBS7 link self-test sequencer: aligner reset, lock settle,
//               fixed-length error window, retry on lock loss, verdict.
// Revision    : 1.0 - initial release
// ============================================================================
module prbs_link_test_ctrl
    import prbs_link_pkg::*;
#(
    parameter int WINDOW_LOG2   = DEF_WINDOW_LOG2,
    parameter int SETTLE        = DEF_SETTLE,
    parameter int ALIGN_TIMEOUT = DEF_ALIGN_TIMEOUT,
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int MAX_RETRY     = DEF_MAX_RETRY,
    parameter int ERR_LIMIT     = DEF_ERR_LIMIT,
    parameter int ERRW          = DEF_ERRW
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   start_i,
    input  logic                   abort_i,
    input  logic                   aligned_i,
    input  logic [ERRW-1:0]        err_bits_i,
    output logic                   align_reset_o,
    output logic                   bypass_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   pass_o,
    output logic                   fail_o,
    output logic [ERR_TOTAL_W-1:0] err_total_o,
    output logic [WINDOW_LOG2:0]   word_cnt_o,
    output logic [1:0]             attempts_o,
    output logic [2:0]             state_o
);

    localparam int c_rst_w = $clog2(RST_CYCLES + 1);
    localparam int c_tmo_w = $clog2(ALIGN_TIMEOUT + 1);
    localparam int c_set_w = $clog2(SETTLE + 1);

    localparam logic [c_rst_w-1:0]     c_rst_last  = c_rst_w'(RST_CYCLES - 1);
    localparam logic [c_tmo_w-1:0]     c_tmo_last  = c_tmo_w'(ALIGN_TIMEOUT - 1);
    localparam logic [c_set_w-1:0]     c_set_last  = c_set_w'(SETTLE - 1);
    localparam logic [WINDOW_LOG2:0]   c_win_last  = {1'b0, {WINDOW_LOG2{1'b1}}};
    localparam logic [ERR_TOTAL_W-1:0] c_err_limit = ERR_TOTAL_W'(ERR_LIMIT);

    state_e                 state_q;
    state_e                 state_d;
    state_e                 w_retry_tgt;
    logic [c_rst_w-1:0]     rst_cnt_q;
    logic [c_tmo_w-1:0]     tmo_cnt_q;
    logic [c_set_w-1:0]     settle_cnt_q;
    logic [WINDOW_LOG2:0]   word_cnt_q;
    logic [1:0]             attempts_q;
    logic                   align_reset_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   pass_q;
    logic                   fail_q;
    logic                   w_meas_entry;
    logic                   w_count_clr;
    logic [ERR_TOTAL_W-1:0] w_err_total;
    logic [ERR_TOTAL_W-1:0] w_err_next;

    always_comb begin
        state_d     = state_q;
        w_retry_tgt = (int'(attempts_q) < MAX_RETRY) ? ST_ALIGN_RST : ST_FAIL;
        case (state_q)
            ST_IDLE: begin
                if (start_i) state_d = ST_ALIGN_RST;
            end
            ST_ALIGN_RST: begin
                if (rst_cnt_q == c_rst_last) state_d = ST_WAIT_ALIGN;
            end
            ST_WAIT_ALIGN: begin
                if (aligned_i)                    state_d = ST_SETTLE_ST;
                else if (tmo_cnt_q >= c_tmo_last) state_d = w_retry_tgt;
            end
            ST_SETTLE_ST: begin
                if (!aligned_i)                       state_d = ST_WAIT_ALIGN;
                else if (settle_cnt_q == c_set_last)  state_d = ST_MEASURE;
            end
            ST_MEASURE: begin
                // the last window word wins over a simultaneous lock loss
                if (word_cnt_q == c_win_last) state_d = ST_DONE;
                else if (!aligned_i)          state_d = w_retry_tgt;
            end
            ST_DONE, ST_FAIL: begin
                if (!start_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort_i) state_d = ST_IDLE;
    end

    assign w_meas_entry = (state_d == ST_MEASURE) && (state_q != ST_MEASURE);
    assign w_count_clr  = (state_d == ST_IDLE) || w_meas_entry;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rst_cnt_q     <= '0;
            tmo_cnt_q     <= '0;
            settle_cnt_q  <= '0;
            word_cnt_q    <= '0;
            attempts_q    <= '0;
            align_reset_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            fail_q        <= 1'b0;
        end else begin
            rst_cnt_q <= ((state_q == ST_ALIGN_RST) && (state_d == ST_ALIGN_RST))
                         ? rst_cnt_q + 1'b1 : '0;

            // timeout budget spans WAIT_ALIGN visits within one attempt
            if ((state_q == ST_WAIT_ALIGN) && !aligned_i) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end else if ((state_q != ST_WAIT_ALIGN) && (state_q != ST_SETTLE_ST)) begin
                tmo_cnt_q <= '0;
            end

            settle_cnt_q <= ((state_q == ST_SETTLE_ST) && (state_d == ST_SETTLE_ST))
                            ? settle_cnt_q + 1'b1 : '0;

            if (w_count_clr) begin
                word_cnt_q <= '0;
            end else if (state_q == ST_MEASURE) begin
                word_cnt_q <= word_cnt_q + 1'b1;
            end

            if (state_d == ST_IDLE) begin
                attempts_q <= '0;
            end else if ((state_d == ST_ALIGN_RST) && (state_q != ST_ALIGN_RST)) begin
                attempts_q <= attempts_q + 2'd1;
            end

            align_reset_q <= (state_d == ST_ALIGN_RST);
            busy_q        <= (state_d == ST_ALIGN_RST) || (state_d == ST_WAIT_ALIGN) ||
                             (state_d == ST_SETTLE_ST) || (state_d == ST_MEASURE);
            done_q        <= (state_d == ST_DONE) && (state_q != ST_DONE);
            fail_q        <= (state_d == ST_FAIL);

            if (state_d != ST_DONE) begin
                pass_q <= 1'b0;
            end else if (state_q != ST_DONE) begin
                pass_q <= (w_err_next <= c_err_limit);
            end
        end
    end

    sat_accum #(
        .IN_W  (ERRW),
        .ACC_W (ERR_TOTAL_W)
    ) u_accum (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .clear_i   (w_count_clr),
        .en_i      (state_q == ST_MEASURE),
        .data_i    (err_bits_i),
        .acc_o     (w_err_total),
        .next_o    (w_err_next)
    );

    assign align_reset_o = align_reset_q;
    assign bypass_o      = 1'b0;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign pass_o        = pass_q;
    assign fail_o        = fail_q;
    assign err_total_o   = w_err_total;
    assign word_cnt_o    = word_cnt_q;
    assign attempts_o    = attempts_q;
    assign state_o       = state_q;

endmodule : prbs_link_test_ctrl
`default_nettype wire

// File: tb/tb_prbs_link_test_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_prbs_link_test_ctrl
// Description : Self-checking bench for prbs_link_test_ctrl with a cycle-level
//               behavioural reference and directed plus randomized stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prbs_link_test_ctrl;

    localparam int WL  = 4;
    localparam int STL = 4;
    localparam int TMO = 32;
    localparam int RC  = 4;
    localparam int MR  = 2;
    localparam int EL  = 0;
    localparam int EW  = 7;
    localparam int WIN = 1 << WL;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          aligned = 1'b0;
    logic [EW-1:0] err_bits = '0;
    logic          align_reset, bypass, busy, done, pass, fail;
    logic [31:0]   err_total;
    logic [WL:0]   word_cnt;
    logic [1:0]    attempts;
    logic [2:0]    state;

    prbs_link_test_ctrl #(
        .WINDOW_LOG2(WL), .SETTLE(STL), .ALIGN_TIMEOUT(TMO), .RST_CYCLES(RC),
        .MAX_RETRY(MR), .ERR_LIMIT(EL), .ERRW(EW)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n), .start_i(start), .abort_i(abort),
        .aligned_i(aligned), .err_bits_i(err_bits), .align_reset_o(align_reset),
        .bypass_o(bypass), .busy_o(busy), .done_o(done), .pass_o(pass),
        .fail_o(fail), .err_total_o(err_total), .word_cnt_o(word_cnt),
        .attempts_o(attempts), .state_o(state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: phase numbers are the documented state codes (0 idle .. 6 fail)
    int     m_st = 0, m_rc = 0, m_tmo = 0, m_sc = 0, m_words = 0, m_att = 0;
    longint m_err = 0;
    bit     m_done = 0, m_pass = 0;

    task automatic m_to_idle();
        m_st = 0; m_err = 0; m_words = 0; m_att = 0; m_pass = 0;
    endtask

    task automatic m_retry();
        if (m_att < MR) begin m_st = 1; m_att++; m_rc = 0; end
        else m_st = 6;
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_to_idle();
            m_done = 0;
        end else begin
            m_done = 0;
            if (abort) m_to_idle();
            else case (m_st)
                0: if (start) begin m_st = 1; m_att = 1; m_rc = 0; end
                1: begin
                    m_rc++;
                    if (m_rc == RC) begin m_st = 2; m_tmo = 0; end
                end
                2: if (aligned) begin m_st = 3; m_sc = 0; end
                   else begin m_tmo++; if (m_tmo >= TMO) m_retry(); end
                3: if (!aligned) m_st = 2;
                   else begin
                       m_sc++;
                       if (m_sc == STL) begin m_st = 4; m_err = 0; m_words = 0; end
                   end
                4: begin
                    m_words++;
                    m_err = m_err + longint'(err_bits);
                    if (m_err > 64'hFFFF_FFFF) m_err = 64'hFFFF_FFFF;
                    if (m_words == WIN) begin m_st = 5; m_done = 1; m_pass = (m_err <= EL); end
                    else if (!aligned) m_retry();
                end
                5, 6: if (!start) m_to_idle();
                default: m_to_idle();
            endcase
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("state",       state,       m_st);
            chk("align_reset", align_reset, (m_st == 1));
            chk("busy",        busy,        (m_st >= 1 && m_st <= 4));
            chk("done",        done,        m_done);
            chk("pass",        pass,        m_pass);
            chk("fail",        fail,        (m_st == 6));
            chk("bypass",      bypass,      0);
            chk("err_total",   err_total,   m_err);
            chk("word_cnt",    word_cnt,    m_words);
            chk("attempts",    attempts,    m_att);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_state(input string what, input int code, input int budget);
        int k;
        k = 0;
        while (int'(state) != code && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(what, state, code);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    int n, hi, rises, first, second, p_loss, lock_at, stop_at;
    bit prev, err_run;

    initial begin
        // reset state
        cyc(3);
        chk("rst_state", state, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err_total", err_total, 0);
        chk("rst_word_cnt", word_cnt, 0);
        reset_n = 1'b1;
        cmp_en  = 1'b1;
        cyc(2);

        // clean run, already locked: start-to-done latency
        aligned = 1'b1;
        start   = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!done && n < 200);
        chk("latency", n, 1 + RC + 1 + STL + WIN);
        chk("clean_pass", pass, 1);
        chk("clean_err_total", err_total, 0);
        chk("clean_word_cnt", word_cnt, 16);
        chk("clean_attempts", attempts, 1);
        cyc(3);
        chk("done_hold", state, 5);
        start = 1'b0;
        cyc(2);
        chk("back_idle", state, 0);

        // lock arrives 3 cycles after align_reset falls
        aligned = 1'b0;
        start   = 1'b1;
        wait_state("reach_align_rst", 1, 10);
        n = 0;
        while (align_reset && n < 20) begin @(negedge clk); n++; end
        cyc(2);
        aligned = 1'b1;
        wait_state("late_lock_done", 5, 100);
        chk("late_lock_pass", pass, 1);
        start = 1'b0;
        cyc(2);

        // two words with 3 error bits each
        start = 1'b1;
        wait_state("err_measure", 4, 40);
        err_bits = 7'd3;
        cyc(2);
        err_bits = 7'd0;
        wait_state("err_done", 5, 40);
        chk("err_total_6", err_total, 6);
        chk("err_pass", pass, 0);
        cyc(5);
        chk("err_hold_state", state, 5);
        chk("err_hold_done", done, 0);
        start = 1'b0;
        cyc(2);

        // alignment timeout on every attempt
        aligned = 1'b0;
        start   = 1'b1;
        hi = 0; rises = 0; first = -1; second = -1; prev = 1'b0;
        for (int c = 1; c <= 200 && !fail; c++) begin
            @(negedge clk);
            if (align_reset) hi++;
            if (align_reset && !prev) begin
                if (first < 0) first = c; else second = c;
                rises++;
            end
            prev = align_reset;
        end
        chk("tmo_pulses", rises, 2);
        chk("tmo_rst_cycles", hi, 8);
        chk("tmo_spacing", second - first, TMO + RC);
        chk("tmo_fail", fail, 1);
        chk("tmo_attempts", attempts, 2);
        start = 1'b0;
        cyc(2);

        // lock lost at word 7, relock, full window
        aligned = 1'b1;
        start   = 1'b1;
        wait_state("loss_measure", 4, 40);
        n = 0;
        while (int'(word_cnt) != 7 && n < 20) begin @(negedge clk); n++; end
        aligned = 1'b0;
        cyc(6);
        aligned = 1'b1;
        wait_state("loss_done", 5, 100);
        chk("loss_attempts", attempts, 2);
        chk("loss_word_cnt", word_cnt, 16);
        start = 1'b0;
        cyc(2);

        // one-cycle glitch after two settle cycles
        aligned = 1'b0;
        start   = 1'b1;
        wait_state("glitch_wait", 2, 20);
        aligned = 1'b1;
        wait_state("glitch_settle", 3, 5);
        cyc(2);
        aligned = 1'b0;
        cyc(1);
        chk("glitch_back_wait", state, 2);
        aligned = 1'b1;
        n = 0;
        while (int'(state) != 4 && n < 20) begin @(negedge clk); n++; end
        chk("glitch_to_measure", n, 1 + STL);

        // abort mid-measure
        cyc(3);
        abort = 1'b1;
        start = 1'b0;
        cyc(1);
        chk("abort_busy", busy, 0);
        chk("abort_state", state, 0);
        abort = 1'b0;
        cyc(2);

        // asynchronous reset while align_reset is high, then mid-measure
        start = 1'b1;
        wait_state("arst_align_rst", 1, 10);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_align_reset", align_reset, 0);
        chk("arst_busy_a", busy, 0);
        start = 1'b0;
        cyc(1);
        reset_n = 1'b1;
        cyc(1);
        start = 1'b1;
        wait_state("arst_measure", 4, 40);
        cyc(3);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_state", state, 0);
        chk("arst_busy", busy, 0);
        chk("arst_word_cnt", word_cnt, 0);
        chk("arst_attempts", attempts, 0);
        start = 1'b0;
        cyc(2);
        reset_n = 1'b1;
        cyc(2);

        // saturation of the error total
        start = 1'b1;
        wait_state("sat_measure", 4, 40);
        cyc(2);
        #2;
        m_err = 64'hFFFF_FFF0;
        force dut.u_accum.acc_q = 32'hFFFF_FFF0;
        err_bits = 7'd127;
        #1 release dut.u_accum.acc_q;
        cyc(1);
        chk("sat_first", err_total, 32'hFFFF_FFFF);
        cyc(1);
        chk("sat_hold", err_total, 32'hFFFF_FFFF);
        wait_state("sat_done", 5, 40);
        chk("sat_pass", pass, 0);
        err_bits = '0;
        start = 1'b0;
        cyc(2);

        // randomized runs
        for (int r = 0; r < 24; r++) begin
            p_loss  = (r % 3 == 0) ? 0 : ((r % 3 == 1) ? 3 : 15);
            lock_at = $urandom_range(0, 45);
            stop_at = $urandom_range(30, 150);
            err_run = (r % 2 == 1);
            for (int c = 0; c < 160; c++) begin
                @(negedge clk);
                start    = (c < stop_at) || ($urandom_range(0, 3) == 0);
                aligned  = (c >= lock_at) && ($urandom_range(0, 99) >= p_loss);
                err_bits = (err_run && $urandom_range(0, 9) == 0) ? EW'($urandom_range(0, 127)) : '0;
                abort    = ($urandom_range(0, 249) == 0);
            end
            @(negedge clk);
            start = 1'b0; abort = 1'b1; err_bits = '0;
            @(negedge clk);
            abort = 1'b0;
            cyc(1);
        end

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_prbs_link_test_ctrl
`default_nettype wire
